// File: rtl/ro_meas_sequencer.sv
// Ring-oscillator measurement sequencer: settle, gated count windows, averaging, 3-byte UART frame.
// Per sample SETTLE+WINDOW+2 cycles; UART bytes paced by tx_busy (waits for high then low per byte).
module ro_meas_sequencer #(
    parameter int WINDOW = 1000,
    parameter int SETTLE = 16,
    parameter int LOG2N  = 2
) (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [15:0] count,
    input  logic        tx_busy,
    output logic        en_inv_osc,
    output logic        en_nand_osc,
    output logic        osc_sel,
    output logic        cnt_clr,
    output logic        cnt_en,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic [15:0] avg,
    output logic        busy,
    output logic        done
);

    localparam int TMAX  = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TW    = $clog2(TMAX + 1);
    localparam int NSAMP = 1 << LOG2N;

    typedef enum logic [3:0] {
        S_IDLE, S_SETTLE, S_COUNT, S_CAPTURE, S_AVG,
        S_SEND, S_WAIT_HI, S_WAIT_LO, S_NEXT
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer;
    logic [8:0]    smp;
    logic [23:0]   acc;
    logic [1:0]    mode_q;
    logic [1:0]    byte_idx;
    logic [7:0]    frame_byte;
    logic          settle_end, count_end, cap_end, last_smp, dual_next, running;

    assign settle_end = (timer == TW'(SETTLE - 1));
    assign count_end  = (timer == TW'(WINDOW - 1));
    assign cap_end    = (timer == TW'(1));
    assign last_smp   = (smp == 9'(NSAMP - 1));
    assign dual_next  = (mode_q == 2'b10) && !osc_sel;

    always_comb begin
        case (byte_idx)
            2'd0:    frame_byte = {7'b1010000, osc_sel};
            2'd1:    frame_byte = avg[15:8];
            default: frame_byte = avg[7:0];
        endcase
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        running   = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                running = 1'b1;
                cnt_clr = (timer == '0);
                if (settle_end) state_nxt = S_COUNT;
            end
            S_COUNT: begin
                running = 1'b1;
                cnt_en  = 1'b1;
                if (count_end) state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                running = 1'b1;
                if (cap_end) state_nxt = last_smp ? S_AVG : S_SETTLE;
            end
            S_AVG:     state_nxt = S_SEND;
            S_SEND:    if (!tx_busy) state_nxt = S_WAIT_HI;
            S_WAIT_HI: if (tx_busy)  state_nxt = S_WAIT_LO;
            S_WAIT_LO: if (!tx_busy) state_nxt = (byte_idx == 2'd2) ? S_NEXT : S_SEND;
            S_NEXT: begin
                if (dual_next) begin
                    state_nxt = S_SETTLE;
                end else begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default:   state_nxt = S_IDLE;
        endcase
        en_inv_osc  = running & ~osc_sel;
        en_nand_osc = running & osc_sel;
    end

    // Timer is shared: settle/window length, then a 2-cycle capture (freeze, then accumulate).
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            timer    <= '0;
            smp      <= '0;
            acc      <= '0;
            mode_q   <= 2'b00;
            osc_sel  <= 1'b0;
            avg      <= '0;
            byte_idx <= 2'd0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        osc_sel <= (mode == 2'b01);
                        acc     <= '0;
                        smp     <= '0;
                    end
                end
                S_SETTLE:  timer <= settle_end ? '0 : timer + 1'b1;
                S_COUNT:   timer <= count_end  ? '0 : timer + 1'b1;
                S_CAPTURE: begin
                    if (!cap_end) begin
                        timer <= TW'(1);
                    end else begin
                        timer <= '0;
                        acc   <= acc + {8'h00, count};
                        if (!last_smp) smp <= smp + 1'b1;
                    end
                end
                S_AVG: begin
                    avg      <= acc[LOG2N+15:LOG2N];
                    byte_idx <= 2'd0;
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= frame_byte;
                    end
                end
                S_WAIT_LO: begin
                    if (!tx_busy && byte_idx != 2'd2) byte_idx <= byte_idx + 1'b1;
                end
                S_NEXT: begin
                    if (dual_next) begin
                        osc_sel <= 1'b1;
                        acc     <= '0;
                        smp     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ro_meas_sequencer.sv
// Scoreboard bench for ro_meas_sequencer: main instance (W=100,S=4,N=4) plus two extreme-parameter instances.
module tb_ro_meas_sequencer;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] count = 16'h0;
    logic        tx_busy = 1'b0;
    logic        en_inv_osc, en_nand_osc, osc_sel, cnt_clr, cnt_en, tx_start, busy, done;
    logic [7:0]  tx_data;
    logic [15:0] avg;

    logic        start8 = 1'b0, start0 = 1'b0;
    logic [1:0]  mode8 = 2'b00, mode0 = 2'b11;
    logic [15:0] count8 = 16'hFFFF, count0 = 16'h0001;
    logic        tx_busy8, tx_busy0;
    logic        eninv8, ennand8, osc8, clr8, cen8, txs8, busy8, done8;
    logic        eninv0, ennand0, osc0, clr0, cen0, txs0, busy0, done0;
    logic [7:0]  txd8, txd0;
    logic [15:0] avg8, avg0;

    always #5 clk1 = ~clk1;

    ro_meas_sequencer #(.WINDOW(100), .SETTLE(4), .LOG2N(2)) u_dut (
        .clk1(clk1), .rst_n(rst_n), .start(start), .mode(mode), .count(count), .tx_busy(tx_busy),
        .en_inv_osc(en_inv_osc), .en_nand_osc(en_nand_osc), .osc_sel(osc_sel), .cnt_clr(cnt_clr),
        .cnt_en(cnt_en), .tx_start(tx_start), .tx_data(tx_data), .avg(avg), .busy(busy), .done(done)
    );

    ro_meas_sequencer #(.WINDOW(2), .SETTLE(1), .LOG2N(8)) u_dut8 (
        .clk1(clk1), .rst_n(rst_n), .start(start8), .mode(mode8), .count(count8), .tx_busy(tx_busy8),
        .en_inv_osc(eninv8), .en_nand_osc(ennand8), .osc_sel(osc8), .cnt_clr(clr8),
        .cnt_en(cen8), .tx_start(txs8), .tx_data(txd8), .avg(avg8), .busy(busy8), .done(done8)
    );

    ro_meas_sequencer #(.WINDOW(2), .SETTLE(1), .LOG2N(0)) u_dut0 (
        .clk1(clk1), .rst_n(rst_n), .start(start0), .mode(mode0), .count(count0), .tx_busy(tx_busy0),
        .en_inv_osc(eninv0), .en_nand_osc(ennand0), .osc_sel(osc0), .cnt_clr(clr0),
        .cnt_en(cen0), .tx_start(txs0), .tx_data(txd0), .avg(avg0), .busy(busy0), .done(done0)
    );

    // Minimal UART for the extreme instances: busy echoes the start pulse.
    assign tx_busy8 = txs8;
    assign tx_busy0 = txs0;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0]  exp_q[$], q8[$], q0[$];
    logic [15:0] cnt_q[$];

    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
    endtask

    task automatic push_counts(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) cnt_q.push_back(v);
    endtask

    // Counter model: garbage while gated, the queued window result once cnt_en falls.
    logic prev_en_m = 1'b0;
    always @(negedge clk1) begin
        if (cnt_clr)                             count = 16'h0;
        else if (cnt_en)                         count = count + 16'h1;
        else if (prev_en_m && cnt_q.size() != 0) count = cnt_q.pop_front();
        prev_en_m = cnt_en;
    end

    // UART model: 5 cycles low after tx_start, then 20 cycles high; hold forces busy.
    int   uc = 0;
    logic hold = 1'b0;
    always @(negedge clk1) begin
        if (tx_start)     uc = 1;
        else if (uc != 0) uc = (uc == 25) ? 0 : uc + 1;
        tx_busy = hold | (uc >= 6);
    end

    int cyc = 0, rise_t = 0, clr_t = 0;
    int tx_n = 0, done_n = 0, nand_n = 0, both_n = 0, osc_chg = 0, osc_bad = 0;
    int clr_dbl = 0, txs_dbl = 0, done_dbl = 0, data_chg = 0, clr_n = 0, rise_n = 0;
    logic prev_en = 1'b0, prev_clr = 1'b0, prev_txs = 1'b0, prev_done = 1'b0;
    logic prev_osc = 1'b0, prev_run = 1'b0;
    logic [7:0] last_data = 8'h00;

    always @(negedge clk1) begin
        cyc++;
        if (tx_start) begin
            tx_n++;
            chk("tx_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) chk("tx_byte", tx_data, exp_q.pop_front());
        end
        if (rst_n && !tx_start && tx_data != last_data) data_chg++;
        last_data = tx_data;
        if (tx_start && prev_txs) txs_dbl++;
        if (done) done_n++;
        if (done && prev_done) done_dbl++;
        if (en_nand_osc) nand_n++;
        if (en_inv_osc && en_nand_osc) both_n++;
        if (osc_sel != prev_osc) begin
            osc_chg++;
            if (prev_run) osc_bad++;
        end
        if (cnt_clr) begin
            clr_n++;
            clr_t = cyc;
            if (prev_clr) clr_dbl++;
        end
        if (cnt_en && !prev_en) begin
            rise_n++;
            rise_t = cyc;
            chk("settle_gap", cyc - clr_t, 4);
        end
        if (!cnt_en && prev_en && rst_n) chk("window_len", cyc - rise_t, 100);
        prev_en = cnt_en; prev_clr = cnt_clr; prev_txs = tx_start; prev_done = done;
        prev_osc = osc_sel; prev_run = en_inv_osc | en_nand_osc | cnt_en;
    end

    always @(negedge clk1) begin
        if (txs8) begin
            chk("x8_expected", q8.size() != 0, 1'b1);
            if (q8.size() != 0) chk("x8_byte", txd8, q8.pop_front());
        end
        if (txs0) begin
            chk("x0_expected", q0.size() != 0, 1'b1);
            if (q0.size() != 0) chk("x0_byte", txd0, q0.pop_front());
        end
    end

    task automatic wait_done(input int which, input int lim);
        int   n = 0;
        logic d = 1'b0;
        while (!d && n < lim) begin
            @(negedge clk1);
            n++;
            d = (which == 0) ? done : (which == 1) ? done8 : done0;
        end
        chk("done_seen", d, 1'b1);
    endtask

    task automatic pulse_start(input logic [1:0] m);
        mode  = m;
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
    endtask

    int tx0, done_b, nand_b, osc_b;

    initial begin
        repeat (3) @(negedge clk1);
        chk("rst_outs", {busy, cnt_en, cnt_clr, en_inv_osc, en_nand_osc, osc_sel, tx_start, done}, 0);
        chk("rst_avg", avg, 0);
        chk("rst_txd", tx_data, 0);
        rst_n = 1'b1;
        @(negedge clk1);
        chk("idle_busy", busy, 0);

        // Inverter run; UART held busy so the frame waits in SEND.
        hold = 1'b1;
        cnt_q.push_back(16'd400); cnt_q.push_back(16'd404);
        cnt_q.push_back(16'd396); cnt_q.push_back(16'd400);
        push_frame(8'hA0, 8'h01, 8'h90);
        tx0 = tx_n; done_b = done_n; nand_b = nand_n;
        @(negedge clk1);
        pulse_start(2'b00);
        chk("t1_busy", busy, 1);
        chk("t1_en_inv", en_inv_osc, 1);
        chk("t1_clr", cnt_clr, 1);
        repeat (3) @(negedge clk1);
        chk("t4_cnt_en", cnt_en, 0);
        @(negedge clk1);
        chk("t5_cnt_en", cnt_en, 1);
        repeat (440) @(negedge clk1);
        chk("hold_no_tx", tx_n - tx0, 0);
        chk("hold_busy", busy, 1);
        pulse_start(2'b10);
        mode = 2'b00;
        hold = 1'b0;
        wait_done(0, 400);
        @(negedge clk1);
        chk("inv_avg", avg, 16'h0190);
        chk("inv_nand_off", nand_n - nand_b, 0);
        chk("inv_done_n", done_n - done_b, 1);
        chk("inv_tx_n", tx_n - tx0, 3);
        chk("inv_idle", busy, 0);
        repeat (200) @(negedge clk1);
        chk("no_restart", busy, 0);

        // Dual run: inverter then NAND.
        push_counts(16'h1234, 4);
        push_counts(16'h0F00, 4);
        push_frame(8'hA0, 8'h12, 8'h34);
        push_frame(8'hA1, 8'h0F, 8'h00);
        tx0 = tx_n; done_b = done_n; osc_b = osc_chg;
        pulse_start(2'b10);
        wait_done(0, 2500);
        @(negedge clk1);
        chk("dual_avg", avg, 16'h0F00);
        chk("dual_done_n", done_n - done_b, 1);
        chk("dual_tx_n", tx_n - tx0, 6);
        chk("dual_osc_chg", osc_chg - osc_b, 1);
        chk("dual_q_empty", exp_q.size(), 0);

        // Reset in COUNT, with a start coinciding with reset.
        pulse_start(2'b00);
        repeat (50) @(negedge clk1);
        chk("pre_rst_cnt_en", cnt_en, 1);
        rst_n = 1'b0;
        @(negedge clk1);
        chk("mid_rst_outs", {busy, cnt_en, cnt_clr, en_inv_osc, en_nand_osc, osc_sel, tx_start, done}, 0);
        chk("mid_rst_avg", avg, 0);
        start = 1'b1;
        repeat (2) @(negedge clk1);
        start = 1'b0;
        rst_n = 1'b1;
        cnt_q.delete();
        @(negedge clk1);
        chk("post_rst_idle", busy, 0);

        // NAND-only run after reset.
        cnt_q.push_back(16'd10); cnt_q.push_back(16'd20);
        cnt_q.push_back(16'd30); cnt_q.push_back(16'd40);
        push_frame(8'hA1, 8'h00, 8'h19);
        pulse_start(2'b01);
        chk("nand_t1_en", en_nand_osc, 1);
        chk("nand_t1_inv", en_inv_osc, 0);
        wait_done(0, 800);
        @(negedge clk1);
        chk("nand_avg", avg, 16'h0019);

        // Extreme parameters.
        q8.push_back(8'hA0); q8.push_back(8'hFF); q8.push_back(8'hFF);
        start8 = 1'b1;
        @(negedge clk1);
        start8 = 1'b0;
        wait_done(1, 3000);
        @(negedge clk1);
        chk("x8_avg", avg8, 16'hFFFF);
        chk("x8_q_empty", q8.size(), 0);

        q0.push_back(8'hA0); q0.push_back(8'h00); q0.push_back(8'h01);
        start0 = 1'b1;
        @(negedge clk1);
        start0 = 1'b0;
        wait_done(2, 200);
        @(negedge clk1);
        chk("x0_avg", avg0, 16'h0001);
        chk("x0_q_empty", q0.size(), 0);

        chk("both_en", both_n, 0);
        chk("osc_sel_in_run", osc_bad, 0);
        chk("clr_single", clr_dbl, 0);
        chk("clr_per_window", clr_n, rise_n);
        chk("tx_start_single", txs_dbl, 0);
        chk("done_single", done_dbl, 0);
        chk("tx_data_stable", data_chg, 0);
        chk("main_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
